// File: rtl/pd_result_scan.sv
// pd_result_scan: sweeps the power-detect RAM after a trigger, pairs the lo/hi
// halves into 64-bit subframe powers, accumulates a saturated sum and a peak
// per antenna, then streams one result record per antenna (valid/ready).
// Stream handshake: a record is transferred on a rising clk edge where
// o_valid && i_ready; while o_valid && !i_ready every record field is held.
module pd_result_scan #(
   parameter int SF_ADDR_NUM = 20,
   parameter int ANT_NUM     = 4,
   parameter int RD_LAT      = 3,
   parameter int ANW         = $clog2(ANT_NUM),
   parameter int SANW        = $clog2(SF_ADDR_NUM),
   parameter int ADNW        = SANW + ANW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            trig,
   input  logic [63:0]     i_thr_lo,
   input  logic [63:0]     i_thr_hi,
   output logic [ADNW:0]   o_raddr,
   input  logic [31:0]     i_rdata,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [ANW-1:0]  o_ant,
   output logic [63:0]     o_sum,
   output logic [63:0]     o_max,
   output logic [SANW-1:0] o_max_sf,
   output logic [1:0]      o_alarm,
   output logic            o_sat,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_trig_miss
);

   localparam logic [ADNW:0]  LAST_ADDR = (ADNW+1)'(2*SF_ADDR_NUM*ANT_NUM - 1);
   localparam logic [ANW-1:0] LAST_ANT  = ANW'(ANT_NUM - 1);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_EMIT, S_DONE} state_t;

   state_t state_q, state_d;

   logic [ADNW:0]   raddr_q;
   logic [63:0]     thr_lo_q, thr_hi_q;
   logic [31:0]     lo_q;

   // read tag pipeline, stage RD_LAT-1 lines up with i_rdata
   logic [RD_LAT-1:0] tag_v_q, tag_h_q;
   logic [ANW-1:0]    tag_ant_q [RD_LAT];
   logic [SANW-1:0]   tag_sf_q  [RD_LAT];

   // per-antenna accumulators
   logic [63:0]     sum_q    [ANT_NUM];
   logic [63:0]     max_q    [ANT_NUM];
   logic [SANW-1:0] max_sf_q [ANT_NUM];
   logic            sat_q    [ANT_NUM];

   // record registers
   logic            valid_q, busy_q, done_q, miss_q, rsat_q;
   logic [ANW-1:0]  emit_ant_q, rant_q;
   logic [63:0]     rsum_q, rmax_q;
   logic [SANW-1:0] rmax_sf_q;
   logic [1:0]      ralarm_q;

   logic            ret_v, ret_h, pending, hs, last_hs;
   logic [ANW-1:0]  ret_ant, rec_sel;
   logic [SANW-1:0] ret_sf;
   logic [63:0]     word;
   logic [64:0]     sum_ext;

   assign ret_v   = tag_v_q[RD_LAT-1];
   assign ret_h   = tag_h_q[RD_LAT-1];
   assign ret_ant = tag_ant_q[RD_LAT-1];
   assign ret_sf  = tag_sf_q[RD_LAT-1];
   assign word    = {i_rdata, lo_q};
   assign sum_ext = {1'b0, sum_q[ret_ant]} + {1'b0, word};
   assign hs      = (state_q == S_EMIT) && valid_q && i_ready;
   assign last_hs = hs && (emit_ant_q == LAST_ANT);
   assign rec_sel = hs ? emit_ant_q + 1'b1 : emit_ant_q;

   // reads still in flight ahead of the retiring stage
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < RD_LAT-1; i++) pending = pending | tag_v_q[i];
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (trig) state_d = S_SCAN;
         S_SCAN:  if (raddr_q == LAST_ADDR) state_d = S_DRAIN;
         S_DRAIN: if (ret_v && !pending) state_d = S_EMIT;
         S_EMIT:  if (last_hs) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // address generator and read tag pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         raddr_q <= '0;
         tag_v_q <= '0;
         tag_h_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_ant_q[i] <= '0;
            tag_sf_q[i]  <= '0;
         end
      end else begin
         if (state_q == S_SCAN && raddr_q != LAST_ADDR) raddr_q <= raddr_q + 1'b1;
         else if (state_q == S_DONE)                    raddr_q <= '0;
         tag_v_q[0]   <= (state_q == S_SCAN);
         tag_h_q[0]   <= raddr_q[0];
         tag_ant_q[0] <= raddr_q[ANW:1];
         tag_sf_q[0]  <= raddr_q[ADNW:ANW+1];
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v_q[i]   <= tag_v_q[i-1];
            tag_h_q[i]   <= tag_h_q[i-1];
            tag_ant_q[i] <= tag_ant_q[i-1];
            tag_sf_q[i]  <= tag_sf_q[i-1];
         end
      end
   end

   // thresholds and per-antenna sum / peak accumulation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thr_lo_q <= '0;
         thr_hi_q <= '0;
         lo_q     <= '0;
         for (int a = 0; a < ANT_NUM; a++) begin
            sum_q[a] <= '0; max_q[a] <= '0; max_sf_q[a] <= '0; sat_q[a] <= 1'b0;
         end
      end else if (state_q == S_IDLE && trig) begin
         thr_lo_q <= i_thr_lo;
         thr_hi_q <= i_thr_hi;
         for (int a = 0; a < ANT_NUM; a++) begin
            sum_q[a] <= '0; max_q[a] <= '0; max_sf_q[a] <= '0; sat_q[a] <= 1'b0;
         end
      end else if (ret_v) begin
         if (!ret_h) begin
            lo_q <= i_rdata;
         end else begin
            if (sum_ext[64]) begin
               sum_q[ret_ant] <= '1;
               sat_q[ret_ant] <= 1'b1;
            end else begin
               sum_q[ret_ant] <= sum_ext[63:0];
            end
            // strict compare keeps the lowest subframe on ties
            if (word > max_q[ret_ant]) begin
               max_q[ret_ant]    <= word;
               max_sf_q[ret_ant] <= ret_sf;
            end
         end
      end
   end

   // record emission, busy/done/miss flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; miss_q <= 1'b0;
         emit_ant_q <= '0; rant_q <= '0; rsum_q <= '0; rmax_q <= '0;
         rmax_sf_q <= '0; ralarm_q <= '0; rsat_q <= 1'b0;
      end else begin
         miss_q <= trig && (state_q != S_IDLE);
         done_q <= last_hs;
         if (state_q == S_IDLE && trig) busy_q <= 1'b1;
         else if (last_hs)              busy_q <= 1'b0;
         if (state_q == S_DRAIN) begin
            emit_ant_q <= '0;
            valid_q    <= 1'b0;
         end else if (state_q == S_EMIT) begin
            if (last_hs) begin
               valid_q <= 1'b0;
            end else if (!valid_q || hs) begin
               valid_q    <= 1'b1;
               emit_ant_q <= rec_sel;
               rant_q     <= rec_sel;
               rsum_q     <= sum_q[rec_sel];
               rmax_q     <= max_q[rec_sel];
               rmax_sf_q  <= max_sf_q[rec_sel];
               rsat_q     <= sat_q[rec_sel];
               ralarm_q   <= {max_q[rec_sel] > thr_hi_q, sum_q[rec_sel] < thr_lo_q};
            end
         end
      end
   end

   assign o_raddr     = raddr_q;
   assign o_valid     = valid_q;
   assign o_ant       = rant_q;
   assign o_sum       = rsum_q;
   assign o_max       = rmax_q;
   assign o_max_sf    = rmax_sf_q;
   assign o_alarm     = ralarm_q;
   assign o_sat       = rsat_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_trig_miss = miss_q;

endmodule

// File: tb/tb_pd_result_scan.sv
// Directed bench for pd_result_scan: behavioural power RAM with 3-clock read
// latency, hand-computed expected records per antenna.
module tb_pd_result_scan;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        trig = 1'b0;
   logic [63:0] i_thr_lo = '0;
   logic [63:0] i_thr_hi = '0;
   logic [7:0]  o_raddr;
   logic [31:0] i_rdata;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [1:0]  o_ant;
   logic [63:0] o_sum, o_max;
   logic [4:0]  o_max_sf;
   logic [1:0]  o_alarm;
   logic        o_sat, o_busy, o_done, o_trig_miss;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [63:0] mem [0:127];
   logic [7:0]  ad_pipe [0:2];

   logic [63:0] exp_sum   [4];
   logic [63:0] exp_max   [4];
   logic [4:0]  exp_sf    [4];
   logic [1:0]  exp_alarm [4];
   logic        exp_sat   [4];

   pd_result_scan dut (
      .clk(clk), .reset(reset), .trig(trig), .i_thr_lo(i_thr_lo), .i_thr_hi(i_thr_hi),
      .o_raddr(o_raddr), .i_rdata(i_rdata), .o_valid(o_valid), .i_ready(i_ready),
      .o_ant(o_ant), .o_sum(o_sum), .o_max(o_max), .o_max_sf(o_max_sf),
      .o_alarm(o_alarm), .o_sat(o_sat), .o_busy(o_busy), .o_done(o_done),
      .o_trig_miss(o_trig_miss)
   );

   // clock
   always #5 clk = ~clk;

   // power RAM model: data for o_raddr appears three clocks later
   initial for (int i = 0; i < 3; i++) ad_pipe[i] = '0;
   always @(posedge clk) begin
      ad_pipe[0] <= o_raddr;
      ad_pipe[1] <= ad_pipe[0];
      ad_pipe[2] <= ad_pipe[1];
   end
   assign i_rdata = ad_pipe[2][0] ? mem[ad_pipe[2][7:1]][63:32] : mem[ad_pipe[2][7:1]][31:0];

   // o_done pulse counter
   always @(negedge clk) if (o_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_pattern1();
      for (int i = 0; i < 128; i++) mem[i] = '0;
      for (int sf = 0; sf < 20; sf++)
         for (int a = 0; a < 4; a++) mem[sf*4+a] = 64'(16*sf + a + 1);
   endtask

   task automatic exp_pattern1();
      for (int a = 0; a < 4; a++) begin
         exp_sum[a] = 64'(3040 + 20*(a+1));
         exp_max[a] = 64'(305 + a);
         exp_sf[a] = 5'd19;
         exp_alarm[a] = 2'b00;
         exp_sat[a] = 1'b0;
      end
   endtask

   // trigger and follow the address stream; optional stray trig at miss_at
   task automatic start_scan(input int miss_at);
      int bad;
      @(negedge clk) trig = 1'b1;
      @(negedge clk) trig = 1'b0;
      chk("busy_rise", {63'd0, o_busy}, 64'd1);
      bad = 0;
      for (int k = 0; k < 160; k++) begin
         if (o_raddr !== 8'(k)) bad++;
         if (k == miss_at) trig = 1'b1;
         if (k == miss_at + 1) begin
            trig = 1'b0;
            chk("trig_miss_pulse", {63'd0, o_trig_miss}, 64'd1);
         end
         if (k == miss_at + 2) chk("trig_miss_clear", {63'd0, o_trig_miss}, 64'd0);
         @(negedge clk);
      end
      chk("addr_stream_errs", 64'(bad), 64'd0);
      chk("raddr_hold", {56'd0, o_raddr}, 64'd159);
   endtask

   // accept records for ant 0..3, optionally stalling one antenna
   task automatic collect(input string name, input int stall_ant, input int stall_cyc);
      int waited, stall_bad, done0;
      done0 = done_cnt;
      for (int a = 0; a < 4; a++) begin
         waited = 0;
         while (o_valid !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
         end
         chk({name, "_valid_timeout"}, {63'd0, waited < 400}, 64'd1);
         chk({name, "_ant"}, {62'd0, o_ant}, 64'(a));
         chk({name, "_sum"}, o_sum, exp_sum[a]);
         chk({name, "_max"}, o_max, exp_max[a]);
         chk({name, "_max_sf"}, {59'd0, o_max_sf}, {59'd0, exp_sf[a]});
         chk({name, "_alarm"}, {62'd0, o_alarm}, {62'd0, exp_alarm[a]});
         chk({name, "_sat"}, {63'd0, o_sat}, {63'd0, exp_sat[a]});
         if (a == stall_ant) begin
            stall_bad = 0;
            for (int c = 0; c < stall_cyc; c++) begin
               @(negedge clk);
               if (o_valid !== 1'b1 || o_ant !== 2'(a) || o_sum !== exp_sum[a] ||
                   o_max !== exp_max[a] || o_max_sf !== exp_sf[a] ||
                   o_alarm !== exp_alarm[a] || o_sat !== exp_sat[a]) stall_bad++;
            end
            chk({name, "_stall_hold_errs"}, 64'(stall_bad), 64'd0);
         end
         i_ready = 1'b1;
         @(negedge clk);
         i_ready = 1'b0;
      end
      chk({name, "_done_pulse"}, {63'd0, o_done}, 64'd1);
      chk({name, "_valid_low"}, {63'd0, o_valid}, 64'd0);
      chk({name, "_busy_low"}, {63'd0, o_busy}, 64'd0);
      @(negedge clk);
      chk({name, "_done_once"}, 64'(done_cnt - done0), 64'd1);
      chk({name, "_raddr_idle"}, {56'd0, o_raddr}, 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_raddr"}, {56'd0, o_raddr}, 64'd0);
      chk({name, "_valid"}, {63'd0, o_valid}, 64'd0);
      chk({name, "_busy"}, {63'd0, o_busy}, 64'd0);
      chk({name, "_done"}, {63'd0, o_done}, 64'd0);
      chk({name, "_miss"}, {63'd0, o_trig_miss}, 64'd0);
      chk({name, "_fields"}, {62'd0, o_ant} | o_sum | o_max | {59'd0, o_max_sf} |
          {62'd0, o_alarm} | {63'd0, o_sat}, 64'd0);
   endtask

   initial begin
      // reset
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // test 1: ramp pattern, thresholds never trip
      fill_pattern1();
      exp_pattern1();
      i_thr_lo = 64'd0;
      i_thr_hi = '1;
      start_scan(-10);
      collect("t1", -1, 0);

      // test 2: constant words, ties keep sf 0
      for (int i = 0; i < 128; i++) mem[i] = 64'd5;
      for (int a = 0; a < 4; a++) begin
         exp_sum[a] = 64'd100; exp_max[a] = 64'd5; exp_sf[a] = 5'd0;
         exp_alarm[a] = 2'b00; exp_sat[a] = 1'b0;
      end
      start_scan(-10);
      collect("t2", -1, 0);

      // test 3: ant2 saturates
      for (int sf = 0; sf < 20; sf++)
         for (int a = 0; a < 4; a++) mem[sf*4+a] = (a == 2) ? 64'h8000_0000_0000_0000 : 64'd1;
      for (int a = 0; a < 4; a++) begin
         exp_sum[a] = 64'd20; exp_max[a] = 64'd1; exp_sf[a] = 5'd0;
         exp_alarm[a] = 2'b00; exp_sat[a] = 1'b0;
      end
      exp_sum[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_max[2] = 64'h8000_0000_0000_0000;
      exp_sat[2] = 1'b1;
      start_scan(-10);
      collect("t3", -1, 0);

      // test 4: alarms
      fill_pattern1();
      exp_pattern1();
      exp_alarm[0] = 2'b01;
      exp_alarm[3] = 2'b10;
      i_thr_lo = 64'd3070;
      i_thr_hi = 64'd307;
      start_scan(-10);
      collect("t4", -1, 0);

      // test 5: back-pressure on ant1
      exp_pattern1();
      i_thr_lo = 64'd0;
      i_thr_hi = '1;
      start_scan(-10);
      collect("t5", 1, 10);

      // test 6: stray trig mid-scan
      start_scan(50);
      collect("t6", -1, 0);

      // reset mid-scan aborts at once
      @(negedge clk) trig = 1'b1;
      @(negedge clk) trig = 1'b0;
      repeat (80) @(negedge clk);
      chk("abort_pre_busy", {63'd0, o_busy}, 64'd1);
      reset = 1'b0;
      #1;
      check_all_zero("abort");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start_scan(-10);
      collect("post_abort", -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
